pc_ir_unit: RTL and testbench
=============================

Name: pc_ir_unit

Overview:
- Program counter and instruction register for the multicycle MIPS core.
- Consumes the control FSM's PC/IR strobes (ir_wr, pc_write, pc_write_cond, pc_source).
- Fetches instructions from instruction memory over a req/ack handshake and presents the latched instruction back to the control FSM.
- Raises stall while a fetch is outstanding, so the FSM holds its state.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- TIMEOUT, 16, maximum cycles to wait for imem_ack before aborting the fetch; must be ≥2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- ir_wr  in  1  request instruction fetch at current PC
- pc_write  in  1  unconditional PC update
- pc_write_cond  in  1  PC update if branch condition true
- pc_source  in  2  next-PC select: 0 alu_result, 1 alu_out, 2 jump target, 3 hold
- alu_result  in  32  combinational ALU output (PC+4 path)
- alu_out  in  32  registered ALU output (branch target)
- alu_zero  in  1  ALU result == 0 (rs-rt compare)
- alu_neg  in  1  ALU result bit 31
- imem_rdata  in  32  instruction memory read data, valid when imem_ack
- imem_ack  in  1  read complete, one-cycle pulse
- imem_req  out  1  read request
- imem_addr  out  32  read address
- pc  out  32  current PC
- instruction  out  32  instruction register
- stall  out  1  fetch outstanding
- fetch_err  out  1  sticky, fetch timed out
- misalign_err  out  1  sticky, PC write with nonzero bits [1:0]

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-fetch:
  - pc = RESET_PC, instruction = 0, imem_req = 0, imem_addr = 0, stall = 0.
  - fetch_err = 0, misalign_err = 0, timeout counter = 0, FSM = IDLE.
- Fetch FSM has two states, IDLE and WAIT.
- IDLE:
  - A rising edge with ir_wr = 1 latches imem_addr = pc (pre-update value) and sets imem_req = 1 and stall = 1; go to WAIT, counter = 0.
  - With ir_wr = 0, stay in IDLE.
- WAIT:
  - imem_req and imem_addr are held stable.
  - imem_ack = 1: instruction <= imem_rdata; imem_req = 0 and stall = 0 on the next cycle; go to IDLE. Fetch latency is ack cycle + 1.
  - No ack: counter increments. When counter reaches TIMEOUT-1 without ack: instruction <= 32'h0 (nop), fetch_err <= 1, drop req, go to IDLE.
  - ir_wr is ignored in WAIT; no queued second request.
- imem_ack in IDLE is ignored.
- PC update takes effect only when stall = 0 at the rising edge. The launch edge counts, so a PC+4 write issued together with ir_wr is accepted.
- next_pc by pc_source:
  - 0: alu_result
  - 1: alu_out
  - 2: {pc[31:28], instruction[25:0], 2'b00}
  - 3: pc (no change)
- PC update rules:
  - pc_write = 1: pc <= next_pc.
  - pc_write_cond = 1 and pc_write = 0: pc <= next_pc only if taken.
  - pc_write has priority over pc_write_cond when both are high.
- Branch taken, decoded from instruction[31:26]:
  - 0x04 beq: alu_zero
  - 0x05 bne: !alu_zero
  - 0x06 blez: alu_neg | alu_zero
  - 0x07 bgtz: !alu_neg & !alu_zero
  - 0x01 with instruction[16] = 0, bltz: alu_neg
  - 0x01 with instruction[16] = 1, bgez: !alu_neg
  - any other opcode: not taken
- Misalignment: if next_pc[1:0] != 0 on an accepted write, pc <= {next_pc[31:2], 2'b00} and misalign_err <= 1 (sticky until reset).
- Simultaneous accepted PC write and fetch launch: fetch uses the old PC; pc takes the new value at the same edge.
- The instruction register changes only on ack or timeout, never on ir_wr alone.

Test Plan:
- Reset, then ir_wr pulse with pc_write = 1, pc_source = 0, alu_result = 0x3004; ack after 3 cycles with rdata = 0x2008_0005 -> imem_addr = 0x3000; pc = 0x3004; instruction = 0x2008_0005; stall high exactly until the cycle after ack.
- instruction = 0x1000_0003 (beq), pc_write_cond = 1, pc_source = 1, alu_out = 0x3010: with alu_zero = 1 -> pc = 0x3010; with alu_zero = 0 -> pc unchanged.
- instruction = 0x0800_0C10 (j), pc = 0x3008, pc_write = 1, pc_source = 2 -> pc = 0x0000_3040.
- Fetch with no ack, TIMEOUT = 16 -> after 16 cycles instruction = 0, fetch_err = 1, imem_req = 0; a later ir_wr fetches normally with fetch_err still 1.
- pc_write with alu_result = 0x3006 -> pc = 0x3004, misalign_err = 1.
- Assert rst during WAIT -> imem_req drops without a clock edge; pc = 0x3000; instruction = 0; a late ack after reset is ignored.

Source files
------------

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter and instruction register for the multicycle
// MIPS core. Fetches instructions from instruction memory over a req/ack
// handshake and holds the control FSM (via stall) while a fetch is pending.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   ir_wr               launch an instruction fetch at the current PC
//   pc_write            unconditional PC update
//   pc_write_cond       PC update when the decoded branch is taken
//   pc_source [1:0]     next-PC select: 0 alu_result, 1 alu_out, 2 jump, 3 hold
//   alu_result [31:0]   combinational ALU output (PC+4 path)
//   alu_out [31:0]      registered ALU output (branch target)
//   alu_zero, alu_neg   ALU compare flags for branch decisions
//   imem_rdata [31:0]   instruction memory read data, valid with imem_ack
//   imem_ack            read complete, one-cycle pulse
//   imem_req            read request (registered)
//   imem_addr [31:0]    read address (registered)
//   pc [31:0]           current program counter
//   instruction [31:0]  instruction register
//   stall               fetch outstanding
//   fetch_err           sticky: a fetch timed out
//   misalign_err        sticky: a PC write had nonzero bits [1:0]
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_wr,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        stall,
    output logic        fetch_err,
    output logic        misalign_err
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic          launch_s;
    logic          done_s;
    logic          abort_s;
    logic [31:0]   next_pc_s;
    logic          taken_s;
    logic          pc_wr_en_s;

    // Fetch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch FSM next-state and launch/complete/abort decode
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ir_wr) begin
                    launch_s    = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                // ir_wr is deliberately ignored here: no queued second fetch
                if (imem_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Fetch datapath: request, address, timeout counter, IR and fetch error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0000_0000;
            stall       <= 1'b0;
            cnt_r       <= '0;
            instruction <= 32'h0000_0000;
            fetch_err   <= 1'b0;
        end else if (launch_s) begin
            // Address is the PC before any update accepted on this same edge
            imem_req  <= 1'b1;
            imem_addr <= pc;
            stall     <= 1'b1;
            cnt_r     <= '0;
        end else if (done_s) begin
            imem_req    <= 1'b0;
            stall       <= 1'b0;
            cnt_r       <= '0;
            instruction <= imem_rdata;
        end else if (abort_s) begin
            // Timed-out fetch leaves a nop in the IR
            imem_req    <= 1'b0;
            stall       <= 1'b0;
            cnt_r       <= '0;
            instruction <= 32'h0000_0000;
            fetch_err   <= 1'b1;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-PC source select
    always_comb begin
        next_pc_s = pc;
        case (pc_source)
            2'd0:    next_pc_s = alu_result;
            2'd1:    next_pc_s = alu_out;
            2'd2:    next_pc_s = {pc[31:28], instruction[25:0], 2'b00};
            2'd3:    next_pc_s = pc;
            default: next_pc_s = pc;
        endcase
    end

    // Branch-taken decode from the latched opcode
    always_comb begin
        taken_s = 1'b0;
        case (instruction[31:26])
            6'h04:   taken_s = alu_zero;
            6'h05:   taken_s = ~alu_zero;
            6'h06:   taken_s = alu_neg | alu_zero;
            6'h07:   taken_s = ~alu_neg & ~alu_zero;
            6'h01: begin
                // REGIMM: rt bit 0 (instruction[16]) selects bgez over bltz
                if (instruction[16]) begin
                    taken_s = ~alu_neg;
                end else begin
                    taken_s = alu_neg;
                end
            end
            default: taken_s = 1'b0;
        endcase
    end

    // PC writes are blocked only while a fetch is already outstanding
    assign pc_wr_en_s = ~stall & (pc_write | (pc_write_cond & taken_s));

    // Program counter and misalignment flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else if (pc_wr_en_s) begin
            pc <= {next_pc_s[31:2], 2'b00};
            if (next_pc_s[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed testbench for pc_ir_unit: fetch handshake, PC update rules,
// branch decode, jump, timeout, misalignment and asynchronous reset.
module tb_pc_ir_unit;

    logic        clk;
    logic        rst;
    logic        ir_wr;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_neg;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        stall;
    logic        fetch_err;
    logic        misalign_err;

    int n_vec;
    int n_err;

    pc_ir_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ir_wr         (ir_wr),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .instruction   (instruction),
        .stall         (stall),
        .fetch_err     (fetch_err),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Complete fetch with ack on the second WAIT cycle
    task automatic fetch(input logic [31:0] data);
        ir_wr = 1'b1;
        step(1);
        ir_wr = 1'b0;
        step(1);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step(1);
        imem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_vec++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0000_3000); end
        n_vec++; if (instruction !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h want 0", instruction); end
        n_vec++; if ({imem_req, stall, fetch_err, misalign_err} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {imem_req, stall, fetch_err, misalign_err}); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_fetch();
        ir_wr = 1'b1; pc_write = 1'b1; pc_source = 2'd0; alu_result = 32'h0000_3004;
        step(1);
        ir_wr = 1'b0; pc_write = 1'b0;
        n_vec++; if (imem_addr !== 32'h0000_3000) begin n_err++; $display("FAIL fetch_addr: got %h want %h", imem_addr, 32'h0000_3000); end
        n_vec++; if (pc !== 32'h0000_3004) begin n_err++; $display("FAIL fetch_pc: got %h want %h", pc, 32'h0000_3004); end
        n_vec++; if ({imem_req, stall} !== 2'b11) begin n_err++; $display("FAIL fetch_req: got %b want 11", {imem_req, stall}); end
        // Second request and PC write while waiting must both be ignored
        ir_wr = 1'b1; pc_write = 1'b1; alu_result = 32'h0000_5000;
        step(1);
        ir_wr = 1'b0; pc_write = 1'b0;
        n_vec++; if (pc !== 32'h0000_3004) begin n_err++; $display("FAIL stall_pc: got %h want %h", pc, 32'h0000_3004); end
        n_vec++; if (imem_addr !== 32'h0000_3000) begin n_err++; $display("FAIL wait_addr: got %h want %h", imem_addr, 32'h0000_3000); end
        step(1);
        n_vec++; if ({stall, instruction} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wait_ir: got %b/%h want 1/0", stall, instruction); end
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        step(1);
        imem_ack = 1'b0; imem_rdata = 32'h0;
        n_vec++; if (instruction !== 32'h2008_0005) begin n_err++; $display("FAIL fetch_ir: got %h want %h", instruction, 32'h2008_0005); end
        n_vec++; if ({imem_req, stall} !== 2'b00) begin n_err++; $display("FAIL fetch_done: got %b want 00", {imem_req, stall}); end
        // Ack while idle is ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step(1);
        imem_ack = 1'b0;
        n_vec++; if (instruction !== 32'h2008_0005) begin n_err++; $display("FAIL idle_ack: got %h want %h", instruction, 32'h2008_0005); end
    endtask

    task automatic test_branch();
        logic [31:0] br_instr [8];
        logic        br_zero  [8];
        logic        br_neg   [8];
        logic        br_taken [8];
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        br_instr = '{32'h1000_0003, 32'h1000_0003, 32'h1400_0003, 32'h1800_0003,
                     32'h1C00_0003, 32'h0400_0003, 32'h0401_0003, 32'h2008_0005};
        br_zero  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        br_neg   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        br_taken = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_pc = 32'h0000_3004;
        for (int i = 0; i < 8; i++) begin
            fetch(br_instr[i]);
            tgt = 32'h0000_3100 + 32'(i * 16);
            pc_write_cond = 1'b1; pc_source = 2'd1; alu_out = tgt;
            alu_zero = br_zero[i]; alu_neg = br_neg[i];
            step(1);
            pc_write_cond = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
            if (br_taken[i]) exp_pc = tgt;
            n_vec++; if (pc !== exp_pc) begin n_err++; $display("FAIL branch_%0d: got %h want %h", i, pc, exp_pc); end
        end
        // pc_write wins over a not-taken conditional write
        pc_write = 1'b1; pc_write_cond = 1'b1; pc_source = 2'd0; alu_result = 32'h0000_3200;
        step(1);
        pc_write = 1'b0; pc_write_cond = 1'b0;
        n_vec++; if (pc !== 32'h0000_3200) begin n_err++; $display("FAIL write_prio: got %h want %h", pc, 32'h0000_3200); end
    endtask

    task automatic test_jump();
        pc_write = 1'b1; pc_source = 2'd0; alu_result = 32'h0000_3008;
        step(1);
        pc_write = 1'b0;
        fetch(32'h0800_0C10);
        pc_write = 1'b1; pc_source = 2'd2;
        step(1);
        n_vec++; if (pc !== 32'h0000_3040) begin n_err++; $display("FAIL jump: got %h want %h", pc, 32'h0000_3040); end
        pc_source = 2'd3; alu_result = 32'h0000_7000;
        step(1);
        pc_write = 1'b0; pc_source = 2'd0;
        n_vec++; if (pc !== 32'h0000_3040) begin n_err++; $display("FAIL hold: got %h want %h", pc, 32'h0000_3040); end
    endtask

    task automatic test_timeout();
        ir_wr = 1'b1;
        step(1);
        ir_wr = 1'b0;
        step(15);
        n_vec++; if ({stall, fetch_err, instruction} !== {1'b1, 1'b0, 32'h0800_0C10}) begin n_err++; $display("FAIL pre_timeout: got %b/%b/%h want 1/0/08000c10", stall, fetch_err, instruction); end
        step(1);
        n_vec++; if (instruction !== 32'h0) begin n_err++; $display("FAIL timeout_ir: got %h want 0", instruction); end
        n_vec++; if ({fetch_err, imem_req, stall} !== 3'b100) begin n_err++; $display("FAIL timeout_flags: got %b want 100", {fetch_err, imem_req, stall}); end
        fetch(32'h1234_5678);
        n_vec++; if ({fetch_err, instruction} !== {1'b1, 32'h1234_5678}) begin n_err++; $display("FAIL after_timeout: got %b/%h want 1/12345678", fetch_err, instruction); end
    endtask

    task automatic test_misalign();
        n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_pre: got %b want 0", misalign_err); end
        pc_write = 1'b1; pc_source = 2'd0; alu_result = 32'h0000_3006;
        step(1);
        n_vec++; if ({misalign_err, pc} !== {1'b1, 32'h0000_3004}) begin n_err++; $display("FAIL misalign: got %b/%h want 1/00003004", misalign_err, pc); end
        alu_result = 32'h0000_3100;
        step(1);
        pc_write = 1'b0;
        n_vec++; if ({misalign_err, pc} !== {1'b1, 32'h0000_3100}) begin n_err++; $display("FAIL misalign_sticky: got %b/%h want 1/00003100", misalign_err, pc); end
    endtask

    task automatic test_reset_mid_fetch();
        ir_wr = 1'b1;
        step(1);
        ir_wr = 1'b0;
        step(1);
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mid_req: got %b want 1", imem_req); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({imem_req, stall, fetch_err, misalign_err} !== 4'b0000) begin n_err++; $display("FAIL async_flags: got %b want 0000", {imem_req, stall, fetch_err, misalign_err}); end
        n_vec++; if ({pc, instruction, imem_addr} !== {32'h0000_3000, 32'h0, 32'h0}) begin n_err++; $display("FAIL async_regs: got %h/%h/%h want 00003000/0/0", pc, instruction, imem_addr); end
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        step(1);
        imem_ack = 1'b0;
        n_vec++; if ({instruction, stall, pc} !== {32'h0, 1'b0, 32'h0000_3000}) begin n_err++; $display("FAIL late_ack: got %h/%b/%h want 0/0/00003000", instruction, stall, pc); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; ir_wr = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0;
        pc_source = 2'd0; alu_result = 32'h0; alu_out = 32'h0;
        alu_zero = 1'b0; alu_neg = 1'b0; imem_rdata = 32'h0; imem_ack = 1'b0;
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_timeout();
        test_misalign();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
